inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the word-aligned PC (`pc_addr`) when the control unit strobes `fetch_req`.
- Issues a single-outstanding request/acknowledge read to instruction memory and holds the returned word in an instruction register until the decoder accepts it.
- Flags a sticky fetch fault (`HALT_if`) on misalignment, out-of-range address or memory timeout.

Parameters:
- `IMEM_BASE`, `32'h01000000`: lowest legal fetch address.
- `IMEM_LAST`, `32'h01000FFC`: highest legal fetch address (inclusive).
- `TIMEOUT`, `16`: maximum cycles `mem_req` may wait for `mem_ack` before fault; range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  control unit: `pc_addr` valid, start a fetch (sampled only when accepting).
- `pc_addr`  in  32  instruction address from the PC.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  32  read address, stable while `mem_req`=1.
- `mem_ack`  in  1  memory: `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  instruction word from memory.
- `inst`  out  32  instruction register to decoder.
- `inst_valid`  out  1  `inst` holds an unconsumed instruction.
- `inst_ack`  in  1  decoder consumes `inst` (effective only when `inst_valid`=1).
- `busy`  out  1  fetch in progress (state REQ).
- `HALT_if`  out  1  sticky fetch fault.

Behaviour:
- **Reset (`rst`=0, asynchronous):**
  - state=IDLE, `mem_req`=0, `mem_addr`=`IMEM_BASE`.
  - `inst`=`32'h00000013` (NOP), `inst_valid`=0, `busy`=0, `HALT_if`=0, timeout counter=0.
  - Reset mid-fetch abandons the request; a later `mem_ack` is ignored until a new REQ.
- **IDLE:**
  - If `fetch_req`=1, latch `pc_addr` and check it:
    - misaligned (`pc_addr[1:0]`≠0), or
    - `pc_addr` < `IMEM_BASE`, or `pc_addr` > `IMEM_LAST`.
  - On check fail → HALT.
  - On check pass → REQ with `mem_addr`=`pc_addr`; `mem_req`=1 from the next cycle.
- **REQ:**
  - `mem_req`=1, `busy`=1.
  - On `mem_ack`=1: `inst`←`mem_rdata`, `inst_valid`←1, `mem_req`←0 → VALID. Minimum latency: `fetch_req` to `inst_valid` is 2 cycles when ack arrives in the first REQ cycle.
  - Counter increments each REQ cycle without ack. Reaching `TIMEOUT` → HALT, `mem_req`←0.
  - `fetch_req` in REQ is ignored; `pc_addr` changes do not affect `mem_addr`.
- **VALID:**
  - `inst_valid`=1, `inst` stable.
  - On `inst_ack`=1 without `fetch_req` → IDLE, `inst_valid`←0.
  - On `inst_ack`=1 and `fetch_req`=1 in the same cycle: back-to-back; perform the IDLE check on `pc_addr` and go directly to REQ or HALT.
  - On `fetch_req` without `inst_ack`: ignored.
- **HALT:**
  - `HALT_if`=1, `mem_req`=0, `inst_valid`=0.
  - Exit only by reset; all inputs ignored.
- `mem_ack` outside REQ is ignored.
- Timeout counter width: 8 bits; cleared on entry to REQ.

Optional Feature:
- Macro: `IF_RANGE_CHECK_EN`.
- Defined: range check against `IMEM_BASE`/`IMEM_LAST` as above.
- Undefined: only the alignment check applies; any aligned address is fetched. Timeout fault remains.

Decomposition:
- Shared header/package `if_defs`:
  - state encoding IDLE=2'd0, REQ=2'd1, VALID=2'd2, HALT=2'd3;
  - NOP constant `32'h00000013`;
  - default `IMEM_BASE`/`IMEM_LAST` values, shared with PC range limits.
- One natural sub-module: `if_timeout_ctr` (clear, enable, terminal-count output compared against `TIMEOUT`).

Test Plan:
- **Reset values:** hold `rst`=0 → `inst`=`32'h00000013`, `inst_valid`=0, `mem_req`=0, `HALT_if`=0.
- **Basic fetch:**
  - Stimulus: `fetch_req` with `pc_addr`=`32'h01000000`, `mem_ack` on the first REQ cycle with `mem_rdata`=`32'h00500093`.
  - Required: `mem_addr`=`32'h01000000`; `inst_valid`=1 two cycles after `fetch_req`; `inst`=`32'h00500093`.
  - Then `inst_ack` → `inst_valid`=0 next cycle.
- **Back-to-back:** in VALID, `inst_ack`+`fetch_req` with `pc_addr`=`32'h01000004` → next cycle `mem_req`=1, `mem_addr`=`32'h01000004`, no IDLE cycle.
- **Slow memory / held outputs:**
  - Stimulus: `mem_ack` delayed 5 cycles; `pc_addr` toggles meanwhile.
  - Required: `mem_addr` and `mem_req` held; `inst` updated only on ack.
- **Timeout:** no `mem_ack` for 16 REQ cycles → `HALT_if`=1, `mem_req`=0; later `mem_ack`/`fetch_req` ignored until reset.
- **Faults:**
  - `pc_addr`=`32'h01000002` → HALT.
  - `pc_addr`=`32'h01001000` → HALT with `IF_RANGE_CHECK_EN` defined; fetched normally without it.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared fetch-stage state encoding, NOP and instruction memory window
package inst_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_REQ   = 2'd1,
      IF_VALID = 2'd2,
      IF_HALT  = 2'd3
   } if_state_e;

   localparam logic [31:0] IF_NOP = 32'h00000013;

   // Window shared with the PC range limits
   localparam logic [31:0] IF_IMEM_BASE = 32'h01000000;
   localparam logic [31:0] IF_IMEM_LAST = 32'h01000FFC;

   localparam int unsigned IF_CTR_W = 8;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch request, instruction memory and decoder handshake bundle
interface inst_fetch_unit_if;

   logic        fetch_req;
   logic [31:0] pc_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ack;
   logic        busy;
   logic        HALT_if;

   modport master (
      input  fetch_req, pc_addr, mem_ack, mem_rdata, inst_ack,
      output mem_req, mem_addr, inst, inst_valid, busy, HALT_if
   );

   modport slave (
      output fetch_req, pc_addr, mem_ack, mem_rdata, inst_ack,
      input  mem_req, mem_addr, inst, inst_valid, busy, HALT_if
   );

endinterface

// File: rtl/inst_fetch_unit_timeout_ctr.sv
// rtl/inst_fetch_unit_timeout_ctr.sv - 8-bit memory wait counter with terminal-count flag
module if_timeout_ctr
   import inst_fetch_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // tc marks the wait cycle whose expiry brings the count up to TIMEOUT
   localparam logic [IF_CTR_W-1:0] TC_VAL = IF_CTR_W'(TIMEOUT - 1);

   logic [IF_CTR_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch with sticky fault; option IF_RANGE_CHECK_EN
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] IMEM_BASE = IF_IMEM_BASE,
   parameter logic [31:0] IMEM_LAST = IF_IMEM_LAST,
   parameter int unsigned TIMEOUT   = 16
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_unit_if.master bus
);

   if_state_e   state;
   if_state_e   state_nxt;
   logic        accept;
   logic        addr_ok;
   logic        range_ok;
   logic        ctr_clr;
   logic        ctr_en;
   logic        tc;
   logic [31:0] mem_addr_q;
   logic [31:0] inst_q;

`ifdef IF_RANGE_CHECK_EN
   assign range_ok = (bus.pc_addr >= IMEM_BASE) && (bus.pc_addr <= IMEM_LAST);
`else
   // Without range checking only an inverted (empty) window rejects addresses
   assign range_ok = (IMEM_LAST >= IMEM_BASE);
`endif

   assign addr_ok = (bus.pc_addr[1:0] == 2'b00) && range_ok;
   assign ctr_clr = accept && addr_ok;
   assign ctr_en  = (state == IF_REQ) && !bus.mem_ack;

   if_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk (clk),
      .rst (rst),
      .clr (ctr_clr),
      .en  (ctr_en),
      .tc  (tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IF_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IF_IDLE: begin
            accept = bus.fetch_req;
         end
         IF_REQ: begin
            if (bus.mem_ack) begin
               state_nxt = IF_VALID;
            end else if (tc) begin
               state_nxt = IF_HALT;
            end
         end
         IF_VALID: begin
            if (bus.inst_ack) begin
               accept    = bus.fetch_req;
               state_nxt = IF_IDLE;
            end
         end
         default: begin
            state_nxt = IF_HALT;
         end
      endcase
      if (accept) begin
         state_nxt = addr_ok ? IF_REQ : IF_HALT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr_q <= IMEM_BASE;
         inst_q     <= IF_NOP;
      end else begin
         if (accept && addr_ok) begin
            mem_addr_q <= bus.pc_addr;
         end
         if ((state == IF_REQ) && bus.mem_ack) begin
            inst_q <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      bus.mem_req    = (state == IF_REQ);
      bus.busy       = (state == IF_REQ);
      bus.inst_valid = (state == IF_VALID);
      bus.HALT_if    = (state == IF_HALT);
      bus.mem_addr   = mem_addr_q;
      bus.inst       = inst_q;
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed and randomized checks of inst_fetch_unit
module tb_inst_fetch_unit;

   localparam logic [31:0] BASE = 32'h01000000;
   localparam logic [31:0] LAST = 32'h01000FFC;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam int          TMO  = 16;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_inst;

   inst_fetch_unit_if bus();

   inst_fetch_unit #(
      .IMEM_BASE (BASE),
      .IMEM_LAST (LAST),
      .TIMEOUT   (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      bit ok;
      ok = (a[1:0] == 2'b00);
`ifdef IF_RANGE_CHECK_EN
      ok = ok && (a >= BASE) && (a <= LAST);
`endif
      return ok;
   endfunction

   task automatic quiet_inputs();
      bus.fetch_req = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.inst_ack  = 1'b0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst = 1'b0;
      @(negedge clk);
      chk("rst.inst", bus.inst, NOP);
      chk("rst.inst_valid", bus.inst_valid, 0);
      chk("rst.mem_req", bus.mem_req, 0);
      chk("rst.halt", bus.HALT_if, 0);
      chk("rst.busy", bus.busy, 0);
      chk("rst.mem_addr", bus.mem_addr, BASE);
      rst      = 1'b1;
      exp_inst = NOP;
   endtask

   task automatic issue(input logic [31:0] a, input bit with_ack, output bit ok);
      ok            = legal(a);
      bus.fetch_req = 1'b1;
      bus.inst_ack  = with_ack;
      bus.pc_addr   = a;
      @(negedge clk);
      bus.fetch_req = 1'b0;
      bus.inst_ack  = 1'b0;
      chk("issue.inst_valid", bus.inst_valid, 0);
      if (ok) begin
         chk("issue.mem_req", bus.mem_req, 1);
         chk("issue.busy", bus.busy, 1);
         chk("issue.mem_addr", bus.mem_addr, a);
      end else begin
         chk("issue.halt", bus.HALT_if, 1);
         chk("issue.mem_req_off", bus.mem_req, 0);
      end
   endtask

   task automatic serve(input logic [31:0] a, input int delay, input logic [31:0] data);
      for (int i = 0; i < delay; i++) begin
         bus.mem_ack   = 1'b0;
         bus.pc_addr   = $urandom;
         bus.fetch_req = 1'($urandom);
         bus.mem_rdata = $urandom;
         @(negedge clk);
         chk("wait.mem_req", bus.mem_req, 1);
         chk("wait.mem_addr", bus.mem_addr, a);
         chk("wait.inst", bus.inst, exp_inst);
      end
      bus.fetch_req = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = data;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      exp_inst    = data;
      chk("ack.inst_valid", bus.inst_valid, 1);
      chk("ack.inst", bus.inst, data);
      chk("ack.mem_req", bus.mem_req, 0);
      chk("ack.busy", bus.busy, 0);
   endtask

   task automatic consume();
      bus.inst_ack = 1'b1;
      @(negedge clk);
      bus.inst_ack = 1'b0;
      chk("consume.inst_valid", bus.inst_valid, 0);
      chk("consume.mem_req", bus.mem_req, 0);
      chk("consume.inst", bus.inst, exp_inst);
   endtask

   initial begin
      bit          ok;
      bit          in_valid;
      logic [31:0] a;
      logic [31:0] d;

      rst           = 1'b0;
      bus.pc_addr   = '0;
      bus.mem_rdata = '0;
      quiet_inputs();
      exp_inst = NOP;
      do_reset();

      issue(BASE, 1'b0, ok);
      serve(BASE, 0, 32'h00500093);

      issue(BASE + 32'd4, 1'b1, ok);
      serve(BASE + 32'd4, 5, $urandom);

      bus.fetch_req = 1'b1;
      bus.pc_addr   = BASE + 32'd64;
      @(negedge clk);
      bus.fetch_req = 1'b0;
      chk("valid_hold.inst_valid", bus.inst_valid, 1);
      chk("valid_hold.mem_req", bus.mem_req, 0);
      consume();

      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("stray_ack.inst", bus.inst, exp_inst);
      chk("stray_ack.inst_valid", bus.inst_valid, 0);

      in_valid = 1'b0;
      for (int n = 0; n < 24; n++) begin
         a = BASE + (32'($urandom_range(0, 1023)) << 2);
         d = $urandom;
         if (in_valid && ($urandom_range(0, 1) == 1)) begin
            issue(a, 1'b1, ok);
         end else begin
            if (in_valid) consume();
            issue(a, 1'b0, ok);
         end
         serve(a, int'($urandom_range(0, TMO - 1)), d);
         in_valid = 1'b1;
      end
      consume();

      issue(LAST, 1'b0, ok);
      serve(LAST, TMO - 1, $urandom);
      consume();

      issue(BASE + 32'd8, 1'b0, ok);
      @(negedge clk);
      do_reset();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("abandon.inst", bus.inst, NOP);
      chk("abandon.inst_valid", bus.inst_valid, 0);
      chk("abandon.mem_req", bus.mem_req, 0);

      issue(BASE + 32'd12, 1'b0, ok);
      for (int i = 1; i <= TMO; i++) begin
         bus.mem_ack = 1'b0;
         @(negedge clk);
         if (i < TMO) begin
            chk("tmo.mem_req", bus.mem_req, 1);
         end else begin
            chk("tmo.halt", bus.HALT_if, 1);
            chk("tmo.mem_req", bus.mem_req, 0);
            chk("tmo.busy", bus.busy, 0);
         end
      end
      bus.mem_ack   = 1'b1;
      bus.fetch_req = 1'b1;
      bus.inst_ack  = 1'b1;
      bus.pc_addr   = BASE;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      quiet_inputs();
      chk("halt_sticky.halt", bus.HALT_if, 1);
      chk("halt_sticky.mem_req", bus.mem_req, 0);
      chk("halt_sticky.inst_valid", bus.inst_valid, 0);
      chk("halt_sticky.inst", bus.inst, exp_inst);
      do_reset();

      issue(32'h01000002, 1'b0, ok);
      @(negedge clk);
      chk("misalign.halt", bus.HALT_if, 1);
      do_reset();

      issue(32'h01001000, 1'b0, ok);
      if (ok) begin
         serve(32'h01001000, 2, $urandom);
         consume();
      end else begin
         do_reset();
      end

      issue(32'h00FFFFFC, 1'b0, ok);
      if (ok) begin
         serve(32'h00FFFFFC, 0, $urandom);
         consume();
      end else begin
         do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
